// File: rtl/div_result_fifo_pkg.sv
// Shared ALU definitions for the divider result path: flag width and the
// packed {result, remainder, flag} entry layout.
package div_result_fifo_pkg;

   localparam int FLAG_W = 4;
   localparam int DIV_W  = 3;

   typedef struct packed {
      logic signed [DIV_W-1:0]  result;
      logic signed [DIV_W-1:0]  remainder;
      logic        [FLAG_W-1:0] flag;
   } div_entry_t;

   // Entry width for an arbitrary operand width, matching the div_entry_t layout.
   function automatic int entry_width(input int w);
      return 2 * w + FLAG_W;
   endfunction

endpackage

// File: rtl/div_result_fifo_if.sv
// Push/pop handshake bundle between the divider, the result FIFO and its consumer.
interface div_result_fifo_if #(
   parameter int WIDTH = 3
);
   import div_result_fifo_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [WIDTH-1:0]  in_result;
   logic signed [WIDTH-1:0]  in_remainder;
   logic        [FLAG_W-1:0] in_flag;

   logic                     out_valid;
   logic                     out_ready;
   logic signed [WIDTH-1:0]  out_result;
   logic signed [WIDTH-1:0]  out_remainder;
   logic        [FLAG_W-1:0] out_flag;

   // FIFO side
   modport slave (
      input  in_valid, in_result, in_remainder, in_flag, out_ready,
      output in_ready, out_valid, out_result, out_remainder, out_flag
   );

   // Producer/consumer side
   modport master (
      output in_valid, in_result, in_remainder, in_flag, out_ready,
      input  in_ready, out_valid, out_result, out_remainder, out_flag
   );

endinterface

// File: rtl/div_result_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module div_result_fifo_mem #(
   parameter int EW    = 10,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   logic [EW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/div_result_fifo.sv
// Result FIFO behind the signed divider: strict-order storage of {result, remainder,
// flag}, occupancy count and a sticky OR of accepted flags.
module div_result_fifo
   import div_result_fifo_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   div_result_fifo_if.slave  bus,
   input  logic              clear_sticky,
   output logic [CW-1:0]     count,
   output logic [FLAG_W-1:0] sticky_flag
);

   typedef struct packed {
      logic signed [WIDTH-1:0]  result;
      logic signed [WIDTH-1:0]  remainder;
      logic        [FLAG_W-1:0] flag;
   } entry_t;

   localparam int            EW       = entry_width(WIDTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [FLAG_W-1:0] sticky_q, sticky_d;

   logic   in_ready;
   logic   out_valid;
   logic   push;
   logic   pop;
   entry_t wr_entry;
   entry_t rd_entry;

   // in_ready deliberately ignores out_ready so a full FIFO never has a
   // ready path that depends combinationally on the consumer.
   always_comb begin
      in_ready  = (count_q < FULL_CNT) && !rst;
      out_valid = (count_q != '0);
      push      = bus.in_valid && in_ready;
      pop       = out_valid && bus.out_ready;

      wr_entry.result    = bus.in_result;
      wr_entry.remainder = bus.in_remainder;
      wr_entry.flag      = bus.in_flag;

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      sticky_d = (clear_sticky ? '0 : sticky_q) | (push ? bus.in_flag : '0);

      if (rst) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         sticky_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
   end

   div_result_fifo_mem #(
      .EW    (EW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   // Head is shown straight from storage; zeros hide stale slots when empty.
   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid;
   assign bus.out_result    = out_valid ? rd_entry.result    : '0;
   assign bus.out_remainder = out_valid ? rd_entry.remainder : '0;
   assign bus.out_flag      = out_valid ? rd_entry.flag      : '0;

   assign count       = count_q;
   assign sticky_flag = sticky_q;

endmodule
